seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit combinational G/E/L comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with optional early exit on the first differing digit.
- Supports signed or unsigned compare per request; start/busy/done handshake.
- Sits beside the ALU datapath and feeds its compare/branch flags; the en gating of the old block is kept.

---
 rtl/alu_cmp_pkg.sv | 23 ++
 rtl/digit_comparator.sv | 18 +
 rtl/seq_magnitude_comparator.sv | 123 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmp_pkg.sv
// rtl/alu_cmp_pkg.sv - shared types, result encoding and slice helper for the sequential comparator
// Purpose: FSM state enum, one-hot {gt,eq,lt} result codes, digit slice-index helper.
// Ports: none (package).
package alu_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result register layout is {gt, eq, lt}; all-zero means "not decided yet".
   localparam logic [2:0] CMP_NONE = 3'b000;
   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_EQ   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;

   // LSB index of digit j, counting digits from the MSB end (digit 0 is the most significant).
   function automatic int digit_lsb(input int width, input int digit, input int j);
      return width - (j + 1) * digit;
   endfunction

endpackage

// File: rtl/digit_comparator.sv
// rtl/digit_comparator.sv - combinational DIGIT-bit unsigned magnitude comparator
// Purpose: compare one digit of the two operands.
// Ports: a, b - DIGIT-bit digits; dgt/deq/dlt - a>b, a==b, a<b.
module digit_comparator #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             dgt,
   output logic             deq,
   output logic             dlt
);

   assign dgt = (a > b);
   assign deq = (a == b);
   assign dlt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-first signed/unsigned magnitude comparator
// Purpose: compares a and b DIGIT bits per clock with start/busy/done handshake and en gating.
// Ports: clk, rst_n (async, active-low), en (freeze + output gate), start, signed_mode, a, b
//        -> busy (in RUN), done (one-cycle result pulse), gt/eq/lt (registered, gated by en).
module seq_magnitude_comparator
   import alu_cmp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0]    LAST     = CW'(NDIG - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   if (WIDTH % DIGIT != 0) begin : g_bad_width
      $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       res_q, res_d;
   logic             accept;
   logic             dgt, deq, dlt;
   logic             show;

   logic [DIGIT-1:0] a_dig [NDIG];
   logic [DIGIT-1:0] b_dig [NDIG];

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      assign a_dig[g] = a_q[digit_lsb(WIDTH, DIGIT, g) +: DIGIT];
      assign b_dig[g] = b_q[digit_lsb(WIDTH, DIGIT, g) +: DIGIT];
   end

   digit_comparator #(.DIGIT(DIGIT)) u_digit (
      .a   (a_dig[cnt_q]),
      .b   (b_dig[cnt_q]),
      .dgt (dgt),
      .deq (deq),
      .dlt (dlt)
   );

   assign accept = en && start && (state_q == IDLE || state_q == DONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      if (accept) begin
         // Flipping the sign bit maps two's complement onto offset binary,
         // so the digit datapath only ever does unsigned compares.
         a_d     = signed_mode ? (a ^ MSB_MASK) : a;
         b_d     = signed_mode ? (b ^ MSB_MASK) : b;
         res_d   = CMP_NONE;
         cnt_d   = '0;
         state_d = RUN;
      end else if (en) begin
         case (state_q)
            RUN: begin
               // Only the first differing digit decides; later ones are ignored.
               if (res_q == CMP_NONE && !deq) begin
                  res_d = {dgt, 1'b0, dlt};
               end
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  if (res_q == CMP_NONE && deq) begin
                     res_d = CMP_EQ;
                  end
               end else if (EARLY_EXIT != 0 && !deq) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= CMP_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // A partially recorded result (EARLY_EXIT=0) must stay hidden until RUN ends.
   assign show = en && (state_q != RUN);
   assign busy = (state_q == RUN);
   assign done = en && (state_q == DONE);
   assign gt   = show && res_q[2];
   assign eq   = show && res_q[1];
   assign lt   = show && res_q[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - scoreboard bench for seq_magnitude_comparator (EARLY_EXIT 1 and 0)
module tb_seq_magnitude_comparator;

   localparam logic [2:0] R_GT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy0, done0, gt0, eq0, lt0;
   logic        busy1, done1, gt1, eq1, lt1;

   typedef struct {
      logic [2:0] res;
      int         lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   failures = 0;

   logic [2:0] o_res0, o_res1;
   int         o_lat0, o_lat1, o_busy0;
   bit         o_leak;

   seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
   );

   seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Launches one operation from a negedge and observes both DUTs until each
   // produces done (or 30 edges pass). Returns at the negedge where the last done was seen.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsm,
                         input int stall_at, input int stall_len, input int poke_at);
      bit seen0 = 0;
      bit seen1 = 0;
      a = ta; b = tb_v; signed_mode = tsm; start = 1'b1; en = 1'b1;
      o_res0 = 'x; o_res1 = 'x; o_lat0 = -1; o_lat1 = -1; o_busy0 = 0; o_leak = 0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 30 && !(seen0 && seen1); n++) begin
         if (n > 0) @(negedge clk);
         if (busy0) o_busy0++;
         if ((busy0 || !en) && {gt0, eq0, lt0} != 3'b000) o_leak = 1;
         if ((busy1 || !en) && {gt1, eq1, lt1} != 3'b000) o_leak = 1;
         if (done0 && !seen0) begin seen0 = 1; o_res0 = {gt0, eq0, lt0}; o_lat0 = n; end
         if (done1 && !seen1) begin seen1 = 1; o_res1 = {gt1, eq1, lt1}; o_lat1 = n; end
         en = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
         if (n == poke_at) begin
            start = 1'b1; a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h1234;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1} !== 10'b0) begin
         failures++;
         $display("FAIL reset_hold: outputs=%b required=0", {busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1});
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1} !== 10'b0) begin
         failures++;
         $display("FAIL reset_release: outputs=%b required=0", {busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1});
      end
   endtask

   task automatic test_equal();
      exp_t e0, e1;
      q0.push_back('{R_EQ, 4}); q1.push_back('{R_EQ, 4});
      run_op(16'h1234, 16'h1234, 1'b0, 0, 0, -1);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 4;
      if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL equal_ee1: res=%b lat=%0d required res=%b lat=%0d", o_res0, o_lat0, e0.res, e0.lat); end
      if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL equal_ee0: res=%b lat=%0d required res=%b lat=%0d", o_res1, o_lat1, e1.res, e1.lat); end
      if (o_busy0 != 4) begin failures++; $display("FAIL equal_busy_cycles: got %0d required 4", o_busy0); end
      if (o_leak) begin failures++; $display("FAIL equal_flags_in_run: got 1 required 0"); end
   endtask

   task automatic test_early_exit();
      exp_t e0, e1;
      logic [2:0] r [2] = '{R_GT, R_LT};
      for (int i = 0; i < 2; i++) begin
         q0.push_back('{r[i], 1}); q1.push_back('{r[i], 4});
         run_op(16'h8000, 16'h7FFF, 1'(i), 0, 0, -1);
         e0 = q0.pop_front(); e1 = q1.pop_front();
         checks += 2;
         if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL early_exit_ee1 sm=%0d: res=%b lat=%0d required res=%b lat=%0d", i, o_res0, o_lat0, e0.res, e0.lat); end
         if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL early_exit_ee0 sm=%0d: res=%b lat=%0d required res=%b lat=%0d", i, o_res1, o_lat1, e1.res, e1.lat); end
      end
   endtask

   task automatic test_fixed_latency();
      exp_t e0, e1;
      logic [15:0] va [2] = '{16'h1235, 16'h2000};
      logic [15:0] vb [2] = '{16'h1234, 16'h1FFF};
      int          l0 [2] = '{4, 1};
      for (int i = 0; i < 2; i++) begin
         q0.push_back('{R_GT, l0[i]}); q1.push_back('{R_GT, 4});
         run_op(va[i], vb[i], 1'b0, 0, 0, -1);
         e0 = q0.pop_front(); e1 = q1.pop_front();
         checks += 3;
         if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL fixed_lat_ee1 #%0d: res=%b lat=%0d required res=%b lat=%0d", i, o_res0, o_lat0, e0.res, e0.lat); end
         if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL fixed_lat_ee0 #%0d: res=%b lat=%0d required res=%b lat=%0d", i, o_res1, o_lat1, e1.res, e1.lat); end
         if (o_leak) begin failures++; $display("FAIL fixed_lat_flags_in_run #%0d: got 1 required 0", i); end
      end
   endtask

   task automatic test_enable_stall();
      exp_t e0, e1;
      q0.push_back('{R_LT, 7}); q1.push_back('{R_LT, 7});
      run_op(16'h0001, 16'h0002, 1'b0, 1, 3, -1);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 3;
      if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL stall_ee1: res=%b lat=%0d required res=%b lat=%0d", o_res0, o_lat0, e0.res, e0.lat); end
      if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL stall_ee0: res=%b lat=%0d required res=%b lat=%0d", o_res1, o_lat1, e1.res, e1.lat); end
      if (o_leak) begin failures++; $display("FAIL stall_gating: flags seen while en low or busy, required none"); end
   endtask

   task automatic test_en_done();
      a = 16'h1235; b = 16'h1234; signed_mode = 1'b0; start = 1'b1; en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({done0, gt0, done1, gt1} !== 4'b1111) begin failures++; $display("FAIL en_done_pre: got %b required 1111", {done0, gt0, done1, gt1}); end
      en = 1'b0;
      #1;
      checks++;
      if ({done0, gt0, eq0, lt0, done1, gt1, eq1, lt1} !== 8'b0) begin failures++; $display("FAIL en_done_gated: got %b required 0", {done0, gt0, eq0, lt0, done1, gt1, eq1, lt1}); end
      @(negedge clk);
      checks++;
      if ({done0, gt0, done1, gt1} !== 4'b0000) begin failures++; $display("FAIL en_done_frozen: got %b required 0000", {done0, gt0, done1, gt1}); end
      en = 1'b1;
      #1;
      checks++;
      if ({done0, gt0, done1, gt1} !== 4'b1111) begin failures++; $display("FAIL en_done_reassert: got %b required 1111", {done0, gt0, done1, gt1}); end
      @(negedge clk);
      checks++;
      if ({done0, gt0, done1, gt1} !== 4'b0101) begin failures++; $display("FAIL en_done_single_pulse: got %b required 0101", {done0, gt0, done1, gt1}); end
      en = 1'b0;
      #1;
      checks++;
      if ({gt0, gt1} !== 2'b00) begin failures++; $display("FAIL en_idle_gated: got %b required 00", {gt0, gt1}); end
      en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abort();
      bit got_done = 0;
      a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1; en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1} !== 10'b0) begin
         failures++;
         $display("FAIL abort_async: outputs=%b required=0", {busy0, done0, gt0, eq0, lt0, busy1, done1, gt1, eq1, lt1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done0 || done1 || busy0 || busy1) got_done = 1;
      end
      checks++;
      if (got_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: activity=%0d required 0", got_done); end
   endtask

   task automatic test_ignored_start();
      exp_t e0, e1;
      q0.push_back('{R_GT, 4}); q1.push_back('{R_GT, 4});
      run_op(16'h1235, 16'h1234, 1'b0, 0, 0, 1);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 2;
      if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL ignored_start_ee1: res=%b lat=%0d required res=%b lat=%0d", o_res0, o_lat0, e0.res, e0.lat); end
      if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL ignored_start_ee0: res=%b lat=%0d required res=%b lat=%0d", o_res1, o_lat1, e1.res, e1.lat); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e0, e1;
      q0.push_back('{R_EQ, 4}); q1.push_back('{R_EQ, 4});
      run_op(16'h1234, 16'h1234, 1'b0, 0, 0, -1);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 3;
      if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL b2b_first_ee1: res=%b lat=%0d required res=%b lat=%0d", o_res0, o_lat0, e0.res, e0.lat); end
      if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL b2b_first_ee0: res=%b lat=%0d required res=%b lat=%0d", o_res1, o_lat1, e1.res, e1.lat); end
      if ({done0, done1} !== 2'b11) begin failures++; $display("FAIL b2b_old_done: got %b required 11", {done0, done1}); end
      // Still inside the DONE cycle: the next start is accepted back-to-back.
      q0.push_back('{R_LT, 1}); q1.push_back('{R_LT, 4});
      run_op(16'hFFFF, 16'h0000, 1'b1, 0, 0, -1);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks += 3;
      if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL b2b_second_ee1: res=%b lat=%0d required res=%b lat=%0d", o_res0, o_lat0, e0.res, e0.lat); end
      if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL b2b_second_ee0: res=%b lat=%0d required res=%b lat=%0d", o_res1, o_lat1, e1.res, e1.lat); end
      if (o_leak) begin failures++; $display("FAIL b2b_flags_cleared: got stale flags, required 0"); end
   endtask

   task automatic test_random();
      exp_t        e0, e1;
      logic [15:0] ra, rb;
      logic        rsm;
      logic [2:0]  r;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         ra  = 16'($urandom);
         rb  = (i % 2 == 0) ? (ra ^ 16'(1 << $urandom_range(15, 0))) : 16'($urandom);
         if (i == 7) rb = ra;
         rsm = 1'($urandom_range(1, 0));
         if (rsm) r = ($signed(ra) > $signed(rb)) ? R_GT : (ra == rb) ? R_EQ : R_LT;
         else     r = (ra > rb) ? R_GT : (ra == rb) ? R_EQ : R_LT;
         lat = 4;
         for (int j = 3; j >= 0; j--) begin
            if (((ra >> (12 - 4 * j)) & 16'hF) != ((rb >> (12 - 4 * j)) & 16'hF)) lat = j + 1;
         end
         q0.push_back('{r, lat}); q1.push_back('{r, 4});
         run_op(ra, rb, rsm, 0, 0, -1);
         e0 = q0.pop_front(); e1 = q1.pop_front();
         checks += 2;
         if ({o_res0, o_lat0} !== {e0.res, e0.lat}) begin failures++; $display("FAIL random_ee1 a=%h b=%h sm=%0d: res=%b lat=%0d required res=%b lat=%0d", ra, rb, rsm, o_res0, o_lat0, e0.res, e0.lat); end
         if ({o_res1, o_lat1} !== {e1.res, e1.lat}) begin failures++; $display("FAIL random_ee0 a=%h b=%h sm=%0d: res=%b lat=%0d required res=%b lat=%0d", ra, rb, rsm, o_res1, o_lat1, e1.res, e1.lat); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_early_exit();
      test_fixed_latency();
      test_enable_stall();
      test_en_done();
      test_abort();
      test_ignored_start();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
